// File: rtl/data_memory_pipe_pkg.sv
// Shared types and constants for the MEM-stage data memory:
// FSM state encoding, latency bound and the response record.
package data_mem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } mem_state_t;

    localparam int MAX_READ_LAT = 4;
    localparam int MAX_DATA_W   = 64;

    // Data field is sized for the widest supported word; narrower
    // instances zero-extend on entry and slice on exit.
    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [MAX_DATA_W-1:0] data;
    } mem_resp_t;

endpackage

// File: rtl/data_memory_pipe_if.sv
// Request/response bus between the MEM stage and the data memory.
interface data_memory_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W/8-1:0]   byte_en;
    logic [ADDR_W-1:0]     mem_address;
    logic [DATA_W-1:0]     write_data;
    logic                  resp_valid;
    logic [DATA_W-1:0]     read_data;
    logic                  resp_err;

    modport master (
        output req_valid, mem_read, mem_write, byte_en, mem_address, write_data,
        input  req_ready, resp_valid, read_data, resp_err
    );

    modport slave (
        input  req_valid, mem_read, mem_write, byte_en, mem_address, write_data,
        output req_ready, resp_valid, read_data, resp_err
    );

endinterface

// File: rtl/data_memory_pipe_resp_pipe.sv
// Fixed-depth response shift register; clearing it on reset drops every
// in-flight response at once.
module mem_resp_pipe
    import data_mem_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  mem_resp_t resp_in,
    output mem_resp_t resp_out
);

    mem_resp_t stage_q [LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage read its
            // predecessor's old value, so the loop order does not matter.
            stage_q[0] <= resp_in;
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign resp_out = stage_q[LAT-1];

endmodule

// File: rtl/data_memory_pipe.sv
// Word-addressed data memory with byte-lane writes, valid/ready requests,
// fixed read latency and a post-reset self-initialisation sequencer.
module data_memory_pipe
    import data_mem_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 16,
    parameter int                ADDR_W     = 32,
    parameter int                READ_LAT   = 2,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_pipe_if.slave  bus,
    output logic               init_done
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W || DEPTH < 1 ||
        READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_param
        $error("data_memory_pipe: unsupported parameter combination");
    end

    mem_state_t       state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic             ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ready      = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d    = ST_IDLE;
                    init_cnt_d = '0;
                end
            end
            ST_IDLE: ready = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    assign bus.req_ready = ready;
    assign init_done     = ready;

    logic             accept, addr_ok, is_rd, is_wr, do_read, do_write;
    logic [IDX_W-1:0] idx;

    assign accept   = bus.req_valid && ready;
    assign addr_ok  = bus.mem_address < ADDR_W'(DEPTH);
    assign idx      = bus.mem_address[IDX_W-1:0];
    assign is_rd    = bus.mem_read && !bus.mem_write;
    assign is_wr    = bus.mem_write && !bus.mem_read;
    assign do_read  = accept && is_rd && addr_ok;
    assign do_write = accept && is_wr && addr_ok;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; the init sequencer rewrites it
    // after every reset, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[init_cnt_q] <= INIT_VALUE;
        end else if (do_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.byte_en[i]) begin
                    mem[idx][8*i +: 8] <= bus.write_data[8*i +: 8];
                end
            end
        end
    end

    mem_resp_t resp_d, resp_q;

    // Reads sample the array before this edge's update; a read never
    // shares an edge with a write, so that is always the current word.
    always_comb begin
        resp_d       = '0;
        resp_d.valid = accept;
        resp_d.err   = accept && !(addr_ok && (is_rd || is_wr));
        if (do_read) begin
            resp_d.data = MAX_DATA_W'(mem[idx]);
        end
    end

    mem_resp_pipe #(
        .LAT (READ_LAT)
    ) u_resp_pipe (
        .clk      (clk),
        .reset    (reset),
        .resp_in  (resp_d),
        .resp_out (resp_q)
    );

    assign bus.resp_valid = resp_q.valid;
    assign bus.resp_err   = resp_q.err;
    assign bus.read_data  = resp_q.data[DATA_W-1:0];

    if (DATA_W < MAX_DATA_W) begin : g_pad
        logic unused_pad;
        assign unused_pad = |resp_q.data[MAX_DATA_W-1:DATA_W];
    end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Self-checking bench: directed scenarios plus random traffic compared
// every cycle against a queue-based behavioural model of the memory.
module tb_data_memory_pipe;

    localparam int          DATA_W     = 32;
    localparam int          DEPTH      = 16;
    localparam int          ADDR_W     = 32;
    localparam int          READ_LAT   = 2;
    localparam logic [31:0] INIT_VALUE = 32'h0;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic init_done;

    data_memory_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_memory_pipe #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .READ_LAT   (READ_LAT),
        .INIT_VALUE (INIT_VALUE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: an array for the words, a queue of responses
    // tagged with the edge count at which they must be visible.
    typedef struct {
        int unsigned due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int unsigned cyc;
    } obs_t;

    exp_t        exp_q[$];
    obs_t        obs_q[$];
    logic [31:0] model_mem [DEPTH];
    int unsigned cyc        = 0;
    int          init_edges = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            init_edges = 0;
        end else begin
            cyc++;
            if (init_edges < DEPTH) begin
                init_edges++;
                if (init_edges == DEPTH)
                    for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_VALUE;
            end else if (bus.req_valid) begin
                exp_t e;
                logic rd, wr, legal;
                rd     = bus.mem_read && !bus.mem_write;
                wr     = bus.mem_write && !bus.mem_read;
                legal  = bus.mem_address < DEPTH;
                e.due  = cyc + READ_LAT - 1;
                e.err  = !(legal && (rd || wr));
                e.data = 32'h0;
                if (!e.err && rd) e.data = model_mem[bus.mem_address];
                if (!e.err && wr)
                    for (int b = 0; b < 4; b++)
                        if (bus.byte_en[b])
                            model_mem[bus.mem_address][8*b +: 8] = bus.write_data[8*b +: 8];
                exp_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        logic        ev, ee, er;
        logic [31:0] ed;
        ev = 1'b0; ee = 1'b0; ed = 32'h0;
        if (reset && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev = 1'b1;
            ee = exp_q[0].err;
            ed = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        er = reset && (init_edges >= DEPTH);
        check("resp", {bus.resp_valid, bus.resp_err, bus.read_data}, {ev, ee, ed});
        check("ready", {bus.req_ready, init_done}, {er, er});
        if (bus.resp_valid) obs_q.push_back('{bus.resp_err, bus.read_data, cyc});
    end

    task automatic drive(input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.byte_en     = be;
        bus.mem_address = addr;
        bus.write_data  = data;
        bus.req_valid   = 1'b1;
    endtask

    task automatic drain();
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (READ_LAT + 2) @(negedge clk);
    endtask

    task automatic wait_init(output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        // A write held during initialisation must never be accepted.
        bus.req_valid   = 1'b1;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b1;
        bus.byte_en     = 4'hF;
        bus.mem_address = 32'd2;
        bus.write_data  = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.req_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_read_data", bus.read_data, 0);

        reset = 1'b1;
        wait_init(k);
        bus.req_valid = 1'b0;
        check("init_edges", k, DEPTH);
        check("init_done", init_done, 1);

        obs_q.delete();
        drive(1, 0, 4'h0, 5, 0);
        drain();
        check("rd5_count", obs_q.size(), 1);
        check("rd5_data", {obs_q[0].err, obs_q[0].data}, {1'b0, 32'h0});

        obs_q.delete();
        drive(0, 1, 4'hF, 3, 32'hDEAD_BEEF);
        drive(1, 0, 4'h0, 3, 0);
        drain();
        check("raw_count", obs_q.size(), 2);
        check("raw_wr_resp", {obs_q[0].err, obs_q[0].data}, {1'b0, 32'h0});
        check("raw_rd_resp", {obs_q[1].err, obs_q[1].data}, {1'b0, 32'hDEAD_BEEF});
        check("raw_spacing", obs_q[1].cyc - obs_q[0].cyc, 1);

        obs_q.delete();
        drive(0, 1, 4'hF, 7, 32'hAABB_CCDD);
        drive(0, 1, 4'b0101, 7, 32'h1122_3344);
        drive(1, 0, 4'h0, 7, 0);
        drain();
        check("lane_rd7", obs_q[2].data, 32'hAA22_CC44);
        check("lane_model7", model_mem[7], 32'hAA22_CC44);

        obs_q.delete();
        drive(0, 1, 4'hF, 16, 32'h5);
        drive(1, 1, 4'hF, 3, 32'h0);
        drive(1, 0, 4'h0, 3, 0);
        drain();
        check("oor_resp", {obs_q[0].err, obs_q[0].data}, {1'b1, 32'h0});
        check("illegal_err", obs_q[1].err, 1);
        check("illegal_nowrite", obs_q[2].data, 32'hDEAD_BEEF);

        obs_q.delete();
        for (int a = 0; a < DEPTH; a++) drive(1, 0, 4'h0, a, 0);
        drain();
        check("sweep_count", obs_q.size(), DEPTH);
        check("sweep_addr2", obs_q[2].data, 32'h0);
        check("sweep_addr3", obs_q[3].data, 32'hDEAD_BEEF);
        check("sweep_addr7", obs_q[7].data, 32'hAA22_CC44);

        obs_q.delete();
        for (int a = 0; a < 4; a++) drive(1, 0, 4'h0, a, 0);
        drain();
        check("b2b_count", obs_q.size(), 4);
        for (int i = 1; i < obs_q.size(); i++)
            check("b2b_spacing", obs_q[i].cyc - obs_q[i-1].cyc, 1);
        check("b2b_last", obs_q[3].data, 32'hDEAD_BEEF);

        for (int n = 0; n < 400; n++) begin
            int op;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.req_valid = 1'b0;
            end else begin
                op = $urandom_range(0, 9);
                drive(op == 0 || (op >= 2 && op <= 5), op == 0 || op >= 6,
                      4'($urandom_range(0, 15)), 32'($urandom_range(0, 19)), $urandom());
            end
        end
        drain();
        check("rand_drained", exp_q.size(), 0);

        obs_q.delete();
        drive(1, 0, 4'h0, 3, 0);
        drive(1, 0, 4'h0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("mid_rst_valid", bus.resp_valid, 0);
        check("mid_rst_data", bus.read_data, 0);
        repeat (4) @(negedge clk);
        check("mid_rst_no_late", obs_q.size(), 0);

        reset = 1'b1;
        wait_init(k);
        check("reinit_edges", k, DEPTH);
        obs_q.delete();
        drive(1, 0, 4'h0, 3, 0);
        drain();
        check("reinit_count", obs_q.size(), 1);
        check("reinit_addr3", {obs_q[0].err, obs_q[0].data}, {1'b0, 32'h0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
